// File: rtl/fiber_evt_pkg.sv
// Shared definitions for the fiber event arbiter: FSM state encoding,
// the default block-trailer tag and the trailer-detect bit position.
package fiber_evt_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_ENDW = 2'd2;

    localparam logic [4:0] TRL_TAG_DEF = 5'h11;
    localparam int         TAG_MSB     = 31;
    localparam int         TAG_LSB     = 27;

    function automatic logic is_trailer(input logic [31:0] word, input logic [4:0] tag);
        return (word[TAG_MSB:TAG_LSB] == tag);
    endfunction

endpackage

// File: rtl/fiber_evt_arbiter_if.sv
// Source-FIFO and link-FIFO handshake bundle of the fiber event arbiter.
// The arbiter uses the master view; the FIFO environment uses the slave view.
interface fiber_evt_arbiter_if;

    logic [1:0]  IN_EMPTY;
    logic [31:0] IN_DATA0;
    logic [31:0] IN_DATA1;
    logic [1:0]  IN_RD;
    logic        OUT_FULL;
    logic        OUT_WR;
    logic [31:0] OUT_DATA;
    logic        OUT_END;

    modport master (
        input  IN_EMPTY, IN_DATA0, IN_DATA1, OUT_FULL,
        output IN_RD, OUT_WR, OUT_DATA, OUT_END
    );

    modport slave (
        output IN_EMPTY, IN_DATA0, IN_DATA1, OUT_FULL,
        input  IN_RD, OUT_WR, OUT_DATA, OUT_END
    );

endinterface

// File: rtl/evt_rr_pick.sv
// Two-way round-robin pick: returns a one-hot winner from the request
// vector, preferring the source that was not served last on a tie.
module evt_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] pick_o
);

    // one-hot winner selection
    always_comb begin
        pick_o = 2'b00;
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = last_i ? 2'b01 : 2'b10;
            default: pick_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/fiber_evt_arbiter.sv
// Block-granular round-robin arbiter moving event blocks from two source
// FIFOs into the link event FIFO, appending an END word after each trailer.
module fiber_evt_arbiter
    import fiber_evt_pkg::*;
#(
    parameter int         CNT_W   = 16,
    parameter logic [4:0] TRL_TAG = TRL_TAG_DEF
) (
    input  logic                CLK,
    input  logic                RSTb,
    input  logic                ENABLE,
    input  logic                LINK_UP,
    fiber_evt_arbiter_if.master bus,
    output logic [1:0]          GRANT,
    output logic [CNT_W-1:0]    BLK_CNT0,
    output logic [CNT_W-1:0]    BLK_CNT1,
    output logic                BUSY
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic [1:0]  req_s;
    logic [1:0]  pick_s;
    logic        run_s;
    logic        gsel_s;
    logic        grant_ok_s;
    logic [31:0] head_s;
    logic        head_empty_s;
    logic [1:0]  rd_s;
    logic        wr_s;
    logic        end_s;
    logic [31:0] data_s;

    // RSTb is folded into run_s so every strobe is forced low during reset
    assign run_s        = RSTb & ENABLE & LINK_UP;
    assign req_s        = ~bus.IN_EMPTY;
    assign gsel_s       = grant_q[1];
    assign grant_ok_s   = (grant_q == 2'b01) || (grant_q == 2'b10);
    assign head_s       = gsel_s ? bus.IN_DATA1 : bus.IN_DATA0;
    assign head_empty_s = bus.IN_EMPTY[gsel_s];

    evt_rr_pick u_pick (
        .req_i  (req_s),
        .last_i (last_q),
        .pick_o (pick_s)
    );

    // next-state, grant, counters and combinational transfer strobes
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        rd_s    = 2'b00;
        wr_s    = 1'b0;
        end_s   = 1'b0;
        data_s  = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (run_s && (req_s != 2'b00)) begin
                    grant_d = pick_s;
                    state_d = ST_XFER;
                end else begin
                    grant_d = 2'b00;
                end
            end
            ST_XFER: begin
                data_s = head_s;
                if (!grant_ok_s) begin
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else if (run_s && !bus.OUT_FULL && !head_empty_s) begin
                    wr_s = 1'b1;
                    rd_s = grant_q;
                    if (is_trailer(head_s, TRL_TAG)) begin
                        state_d = ST_ENDW;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_ENDW: begin
                end_s = RSTb;
                if (!grant_ok_s) begin
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else if (run_s && !bus.OUT_FULL) begin
                    wr_s = 1'b1;
                    if (gsel_s) begin
                        cnt1_d = cnt1_q + CNT_ONE;
                    end else begin
                        cnt0_d = cnt0_q + CNT_ONE;
                    end
                    last_d  = gsel_s;
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ENDW;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus.IN_RD    = rd_s;
    assign bus.OUT_WR   = wr_s;
    assign bus.OUT_DATA = data_s;
    assign bus.OUT_END  = end_s;
    assign GRANT        = grant_q;
    assign BLK_CNT0     = cnt0_q;
    assign BLK_CNT1     = cnt1_q;
    assign BUSY         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fiber_evt_arbiter.sv
// Scoreboard bench for fiber_evt_arbiter: queue-modelled source FIFOs, a
// block-level reference model and a monitor comparing every link write.
module tb_fiber_evt_arbiter;

    localparam int CW = 4;

    typedef struct packed {
        logic        end_w;
        logic        src;
        logic [31:0] data;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RSTb = 1'b0;
    logic          ENABLE = 1'b0;
    logic          LINK_UP = 1'b0;
    logic [1:0]    GRANT;
    logic [CW-1:0] BLK_CNT0;
    logic [CW-1:0] BLK_CNT1;
    logic          BUSY;

    fiber_evt_arbiter_if bus ();

    fiber_evt_arbiter #(.CNT_W(CW), .TRL_TAG(5'h11)) dut (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .ENABLE   (ENABLE),
        .LINK_UP  (LINK_UP),
        .bus      (bus),
        .GRANT    (GRANT),
        .BLK_CNT0 (BLK_CNT0),
        .BLK_CNT1 (BLK_CNT1),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    logic [31:0] src0_q[$];
    logic [31:0] src1_q[$];
    logic [31:0] m0[$];
    logic [31:0] m1[$];
    exp_t        exp_q[$];
    int          cnt_m[2];
    logic        last_m = 1'b1;
    int          n_chk = 0;
    int          n_err = 0;
    bit          rand_mode = 1'b0;
    logic [1:0]  rd_pend = 2'b00;
    bit          glog = 1'b0;
    logic [1:0]  gprev = 2'b00;
    logic [1:0]  gseq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: blocks alternate between sources, a lone non-empty source
    // always wins, each block is its words up to the trailer then one END.
    function automatic void model_run();
        exp_t        e;
        logic [31:0] w;
        logic        s;
        while (m0.size() > 0 || m1.size() > 0) begin
            if (m0.size() > 0 && m1.size() > 0) s = ~last_m;
            else                                s = (m0.size() == 0);
            w = 32'h0;
            while ((s ? m1.size() : m0.size()) > 0 && w[31:27] != 5'h11) begin
                w = s ? m1.pop_front() : m0.pop_front();
                e.end_w = 1'b0; e.src = s; e.data = w;
                exp_q.push_back(e);
            end
            e.end_w = 1'b1; e.src = s; e.data = 32'h0;
            exp_q.push_back(e);
            cnt_m[s] = (cnt_m[s] + 1) % (1 << CW);
            last_m   = s;
        end
    endfunction

    task automatic push_word(input int s, input logic [31:0] w);
        if (s == 0) begin src0_q.push_back(w); m0.push_back(w); end
        else        begin src1_q.push_back(w); m1.push_back(w); end
    endtask

    task automatic add_block(input int s, input int len);
        logic [31:0] w;
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            if (i == len - 1)            w[31:27] = 5'h11;
            else if (w[31:27] == 5'h11)  w[27] = ~w[27];
            push_word(s, w);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic flush_all();
        src0_q.delete(); src1_q.delete();
        m0.delete(); m1.delete(); exp_q.delete();
        last_m = 1'b1;
        cnt_m  = '{0, 0};
    endtask

    task automatic do_reset();
        step();
        RSTb = 1'b0;
        flush_all();
        repeat (2) @(posedge CLK);
        #2;
        RSTb = 1'b1;
    endtask

    task automatic wait_wr(input string name);
        bit hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK); #1;
            if (bus.OUT_WR) begin hit = 1'b1; break; end
        end
        if (!hit) begin
            n_chk++; n_err++;
            $display("FAIL %s: no write within 200 cycles, required one", name);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK); #1;
            if (exp_q.size() == 0 && !BUSY) begin done = 1'b1; break; end
        end
        if (!done) begin
            n_chk++; n_err++;
            $display("FAIL %s: timeout, %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Source FIFO model: pop what was read at the last edge, present new heads
    initial begin : drv
        bus.IN_EMPTY = 2'b11;
        bus.IN_DATA0 = 32'h0;
        bus.IN_DATA1 = 32'h0;
        bus.OUT_FULL = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (rd_pend[0] && src0_q.size() > 0) void'(src0_q.pop_front());
            if (rd_pend[1] && src1_q.size() > 0) void'(src1_q.pop_front());
            rd_pend = 2'b00;
            if (rand_mode) begin
                ENABLE       = ($urandom_range(0, 9) != 0);
                LINK_UP      = ($urandom_range(0, 19) != 0);
                bus.OUT_FULL = ($urandom_range(0, 3) == 0);
            end
            bus.IN_EMPTY[0] = (src0_q.size() == 0);
            bus.IN_EMPTY[1] = (src1_q.size() == 0);
            bus.IN_DATA0    = (src0_q.size() > 0) ? src0_q[0] : 32'hDEAD_0000;
            bus.IN_DATA1    = (src1_q.size() > 0) ? src1_q[0] : 32'hDEAD_0001;
        end
    end

    // Monitor: every link write is popped from the scoreboard and compared
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge CLK);
            rd_pend = bus.IN_RD;
            if (glog && GRANT != gprev) gseq.push_back(GRANT);
            gprev = GRANT;
            if (!BUSY && (bus.OUT_WR || bus.OUT_END || bus.IN_RD != 2'b00))
                chk("idle_strobes", {bus.OUT_WR, bus.OUT_END, bus.IN_RD}, 4'b0000);
            if (bus.OUT_WR === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_write: got data %h end %b, required no write",
                             bus.OUT_DATA, bus.OUT_END);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.OUT_DATA, e.data);
                    chk("out_end", bus.OUT_END, e.end_w);
                    chk("wr_grant", GRANT, e.src ? 2'b10 : 2'b01);
                    chk("in_rd", bus.IN_RD, e.end_w ? 2'b00 : (e.src ? 2'b10 : 2'b01));
                end
            end else if (bus.IN_RD != 2'b00) begin
                chk("rd_without_wr", bus.IN_RD, 2'b00);
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0] gexp [4];
        gexp = '{2'b01, 2'b00, 2'b10, 2'b00};
        cnt_m = '{0, 0};

        // reset with live inputs: strobes must stay low
        ENABLE = 1'b1; LINK_UP = 1'b1;
        src0_q.push_back(32'h1234_5678);
        src1_q.push_back(32'h8800_0001);
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_in_rd", bus.IN_RD, 2'b00);
        chk("rst_out_wr", bus.OUT_WR, 1'b0);
        chk("rst_out_end", bus.OUT_END, 1'b0);
        chk("rst_grant", GRANT, 2'b00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_cnt0", BLK_CNT0, 0);
        chk("rst_cnt1", BLK_CNT1, 0);
        step(); flush_all(); step(); step();
        RSTb = 1'b1;

        // single three-word block on source 0
        push_word(0, 32'h0000_00A1);
        push_word(0, 32'h4000_00A2);
        push_word(0, 32'h8800_0005);
        model_run();
        wait_drain("blk3", 200);
        chk("blk3_cnt0", BLK_CNT0, 1);
        chk("blk3_cnt1", BLK_CNT1, 0);

        // tie after reset: source 0 first, then source 1
        do_reset();
        ENABLE = 1'b0;
        add_block(0, 2);
        add_block(1, 2);
        model_run();
        gseq.delete();
        glog = 1'b1;
        step(); ENABLE = 1'b1;
        wait_drain("tie", 300);
        glog = 1'b0;
        chk("gseq_len", gseq.size(), 4);
        for (int i = 0; i < gseq.size() && i < 4; i++) chk("gseq", gseq[i], gexp[i]);

        // ENABLE drop mid-block while source 1 waits
        do_reset();
        ENABLE = 1'b0;
        add_block(0, 5);
        add_block(1, 2);
        model_run();
        step(); ENABLE = 1'b1;
        wait_wr("en_first");
        step(); ENABLE = 1'b0;
        repeat (5) begin
            @(negedge CLK); #1;
            chk("en_low_grant", GRANT, 2'b01);
            chk("en_low_rd", bus.IN_RD, 2'b00);
            chk("en_low_wr", bus.OUT_WR, 1'b0);
        end
        step(); ENABLE = 1'b1;
        wait_drain("en_resume", 300);
        chk("en_cnt0", BLK_CNT0, 1);
        chk("en_cnt1", BLK_CNT1, 1);

        // link FIFO full for 4 cycles on the trailer
        push_word(0, 32'h1111_0001);
        push_word(0, 32'h8A00_00F0);
        model_run();
        wait_wr("full_first");
        step(); bus.OUT_FULL = 1'b1;
        repeat (4) begin
            @(negedge CLK); #1;
            chk("full_wr", bus.OUT_WR, 1'b0);
            chk("full_rd", bus.IN_RD, 2'b00);
        end
        step(); bus.OUT_FULL = 1'b0;
        @(negedge CLK); #1;
        chk("full_rel_wr", bus.OUT_WR, 1'b1);
        chk("full_rel_data", bus.OUT_DATA, 32'h8A00_00F0);
        wait_drain("full_end", 200);

        // randomized phases with random stalls
        rand_mode = 1'b1;
        for (int p = 0; p < 20; p++) begin
            for (int s = 0; s < 2; s++) begin
                int nb;
                nb = $urandom_range(0, 3);
                for (int b = 0; b < nb; b++) add_block(s, $urandom_range(1, 4));
            end
            model_run();
            wait_drain("rand_phase", 3000);
            chk("rand_cnt0", BLK_CNT0, cnt_m[0]);
            chk("rand_cnt1", BLK_CNT1, cnt_m[1]);
        end
        rand_mode = 1'b0;
        step();
        ENABLE = 1'b1; LINK_UP = 1'b1; bus.OUT_FULL = 1'b0;
        wait_drain("rand_tail", 200);

        // reset in XFER abandons the block
        add_block(0, 2);
        add_block(0, 6);
        model_run();
        wait_wr("rst_mid_first");
        step();
        RSTb = 1'b0;
        flush_all();
        @(negedge CLK); #1;
        chk("rstmid_wr", bus.OUT_WR, 1'b0);
        chk("rstmid_rd", bus.IN_RD, 2'b00);
        chk("rstmid_end", bus.OUT_END, 1'b0);
        @(negedge CLK); #1;
        chk("rstmid_grant", GRANT, 2'b00);
        chk("rstmid_busy", BUSY, 1'b0);
        chk("rstmid_cnt0", BLK_CNT0, 0);
        chk("rstmid_cnt1", BLK_CNT1, 0);
        step(); RSTb = 1'b1;

        // counter wrap at 2^CW-1
        for (int i = 0; i < 15; i++) push_word(0, 32'h8800_0100 + 32'(i));
        model_run();
        wait_drain("wrap_fill", 400);
        chk("wrap_pre", BLK_CNT0, cnt_m[0]);
        push_word(0, 32'h8FFF_FFFF);
        model_run();
        wait_drain("wrap_last", 100);
        chk("wrap_zero", BLK_CNT0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
